// File: rtl/psum_skew_tx.sv
// psum_skew_tx: transmit end of the systolic-array to accumulator psum path.
// Takes aligned psum rows on a valid/ready handshake and re-emits each row as
// a diagonal staircase: lane PE_SIZE-1 first, lane 0 PE_SIZE-1 cycles later.
// Rows are framed into tiles of TILE_ROWS. After each tile, input is held off
// while the staircase drains and then for a fixed inter-tile gap.
//
// Build option: PSUM_SKEW_ZERO_FILL_EN
//   defined   - a lane's data output reads 0 whenever its enable is low
//   undefined - a lane's data output keeps whatever was last shifted in,
//               including the contents of bubble cycles
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for the first row of a tile, ready high
// STREAM | accepting rows of the current tile, ready high
// DRAIN  | last row accepted, staircase emptying (PE_SIZE cycles)
// GAP    | inter-tile idle period (GAP_CYCLES cycles), ready low
module psum_skew_tx #(
    parameter int PE_SIZE    = 14,
    parameter int PSUM_WIDTH = 32,
    parameter int TILE_ROWS  = 70,
    parameter int GAP_CYCLES = 5,
    parameter int TILE_NUM   = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          psum_valid_i,
    output logic                          psum_ready_o,
    input  logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_i,
    output logic [PE_SIZE-1:0]            psum_en_row_o,
    output logic [PSUM_WIDTH*PE_SIZE-1:0] psum_row_o,
    output logic                          tile_done_o,
    output logic                          last_tile_o,
    output logic                          busy_o
);

    localparam int ROW_W  = $clog2(TILE_ROWS + 1);
    localparam int TILE_W = $clog2(TILE_NUM + 1);
    localparam int PH_MAX = (PE_SIZE > GAP_CYCLES) ? PE_SIZE : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic [TILE_W-1:0] tile_cnt_q, tile_cnt_d;
    logic [PH_W-1:0]   phase_cnt_q, phase_cnt_d;
    logic              ready_q, ready_d;
    logic              tile_done_q, tile_done_d;
    logic              last_tile_q, last_tile_d;

    logic              accept;
    logic [PE_SIZE-1:0] lane_busy;

    assign accept = psum_valid_i & ready_q;

    // Next-state logic: row framing, drain/gap down-counter, tile counter and
    // the registered handshake/status outputs derived from the next state.
    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        phase_cnt_d = phase_cnt_q;
        tile_cnt_d  = tile_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (TILE_ROWS == 1) begin
                        state_d     = S_DRAIN;
                        row_cnt_d   = '0;
                        phase_cnt_d = PH_W'(PE_SIZE - 1);
                    end else begin
                        state_d   = S_STREAM;
                        row_cnt_d = ROW_W'(1);
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    if (row_cnt_q == ROW_W'(TILE_ROWS - 1)) begin
                        state_d     = S_DRAIN;
                        row_cnt_d   = '0;
                        phase_cnt_d = PH_W'(PE_SIZE - 1);
                    end else begin
                        row_cnt_d = row_cnt_q + ROW_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (phase_cnt_q == '0) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d     = S_GAP;
                        phase_cnt_d = PH_W'(GAP_CYCLES - 1);
                    end
                end else begin
                    phase_cnt_d = phase_cnt_q - PH_W'(1);
                end
            end
            S_GAP: begin
                if (phase_cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    phase_cnt_d = phase_cnt_q - PH_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The pulse cycle still belongs to the finishing tile, so the count
        // advances on the edge that ends the pulse.
        if (tile_done_q) begin
            tile_cnt_d = (tile_cnt_q == TILE_W'(TILE_NUM - 1)) ? '0 : tile_cnt_q + TILE_W'(1);
        end

        ready_d     = (state_d == S_IDLE) || (state_d == S_STREAM);
        // Last DRAIN cycle is exactly when lane 0 carries the tile's last row.
        tile_done_d = (state_d == S_DRAIN) && (phase_cnt_d == '0);
        last_tile_d = (tile_cnt_d == TILE_W'(TILE_NUM - 1));
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            row_cnt_q   <= '0;
            tile_cnt_q  <= '0;
            phase_cnt_q <= '0;
            ready_q     <= 1'b1;
            tile_done_q <= 1'b0;
            last_tile_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_cnt_q   <= row_cnt_d;
            tile_cnt_q  <= tile_cnt_d;
            phase_cnt_q <= phase_cnt_d;
            ready_q     <= ready_d;
            tile_done_q <= tile_done_d;
            last_tile_q <= last_tile_d;
        end
    end

    // Per-lane skew lines. Lane i is PE_SIZE-i stages deep; stage 0 loads
    // every cycle, with en marking whether that cycle carried an accepted row.
    for (genvar i = 0; i < PE_SIZE; i++) begin : g_lane
        localparam int D = PE_SIZE - i;

        logic [D-1:0]                 en_sr_q, en_sr_d;
        logic [D-1:0][PSUM_WIDTH-1:0] dat_sr_q, dat_sr_d;

        if (D == 1) begin : g_d1
            // Single-stage lane loads directly from the input.
            always_comb begin
                en_sr_d  = accept;
                dat_sr_d = psum_row_i[i*PSUM_WIDTH +: PSUM_WIDTH];
            end
        end else begin : g_dn
            // Shift toward the output stage (index D-1).
            always_comb begin
                en_sr_d  = {en_sr_q[D-2:0], accept};
                dat_sr_d = {dat_sr_q[D-2:0], psum_row_i[i*PSUM_WIDTH +: PSUM_WIDTH]};
            end
        end

        // Lane shift register; reset drops everything in flight.
        always_ff @(posedge clk) begin
            if (rst_n) begin
                en_sr_q  <= '0;
                dat_sr_q <= '0;
            end else begin
                en_sr_q  <= en_sr_d;
                dat_sr_q <= dat_sr_d;
            end
        end

        assign psum_en_row_o[i] = en_sr_q[D-1];
`ifdef PSUM_SKEW_ZERO_FILL_EN
        assign psum_row_o[i*PSUM_WIDTH +: PSUM_WIDTH] = en_sr_q[D-1] ? dat_sr_q[D-1] : '0;
`else
        assign psum_row_o[i*PSUM_WIDTH +: PSUM_WIDTH] = dat_sr_q[D-1];
`endif
        assign lane_busy[i] = |en_sr_q;
    end

    assign psum_ready_o = ready_q;
    assign tile_done_o  = tile_done_q;
    assign last_tile_o  = last_tile_q;
    assign busy_o       = (state_q != S_IDLE) || (|lane_busy);

endmodule

// File: doc/psum_skew_tx.md
Name: psum_skew_tx

Overview:
- Transmit end of the systolic-array → accumulator psum interface. Accepts unskewed psum rows (all PE_SIZE lanes aligned) from the psum staging buffer over a valid/ready handshake.
- Re-emits each row as the diagonal staircase the accumulator expects on psum_en_row / psum_row: lane PE_SIZE-1 first, lane 0 last.
- Frames rows into tiles and enforces the inter-tile gap that models ifmap preload delay.

Parameters:
- PE_SIZE, 14, number of lanes / systolic columns
- PSUM_WIDTH, 32, bits per lane psum word
- TILE_ROWS, 70, rows per tile (= weight column count)
- GAP_CYCLES, 5, idle cycles forced between tiles
- TILE_NUM, 20, tiles per layer; the tile counter wraps after this many

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-high (1 = reset asserted)
- psum_valid_i  in  1  input row valid
- psum_ready_o  out  1  input row ready
- psum_row_i  in  PSUM_WIDTH*PE_SIZE  aligned row; lane i = bits [i*PSUM_WIDTH +: PSUM_WIDTH]
- psum_en_row_o  out  PE_SIZE  skewed per-lane write enable to the accumulator
- psum_row_o  out  PSUM_WIDTH*PE_SIZE  skewed per-lane data
- tile_done_o  out  1  one-cycle pulse when the last lane of the last row of a tile is emitted
- last_tile_o  out  1  high while the current tile index is TILE_NUM-1
- busy_o  out  1  high when the FSM is not IDLE, or any enable is still in flight

Behaviour:
- Reset values: psum_en_row_o=0, psum_row_o=0, tile_done_o=0, last_tile_o=0, busy_o=0, psum_ready_o=1. FSM=IDLE; row and tile counters=0; all skew registers cleared.
- Accept = psum_valid_i & psum_ready_o, sampled at a rising edge.
- Skew: a row accepted at edge T drives lane i on the outputs from edge T+1+(PE_SIZE-1-i).
  - Lane PE_SIZE-1 appears at T+1; lane 0 appears at T+PE_SIZE.
  - Each lane uses a shift register of depth PE_SIZE-i carrying {en, data}.
- No valid at an edge injects en=0 into every lane's shift register, producing a skewed one-cycle hole per lane. There is no downstream backpressure.
- FSM states:
  - IDLE: ready=1. On accept, row_cnt←1 and go to STREAM. If TILE_ROWS==1, go directly to DRAIN.
  - STREAM: ready=1. Each accept increments row_cnt. An accept with row_cnt==TILE_ROWS-1 goes to DRAIN and row_cnt←0.
  - DRAIN: ready=0 for exactly PE_SIZE cycles. tile_done_o=1 in the cycle psum_en_row_o[0] carries the tile's last row. Then go to GAP.
  - GAP: ready=0 for exactly GAP_CYCLES cycles, then IDLE. If GAP_CYCLES==0, go DRAIN→IDLE directly.
- Tile counter:
  - Increments on tile_done_o; wraps from TILE_NUM-1 to 0.
  - last_tile_o = (tile_cnt==TILE_NUM-1), registered, updated with the counter.
- Per tile, ready is low for PE_SIZE+GAP_CYCLES cycles (19 at defaults).
- Simultaneous events: the accept of the tile's last row and the DRAIN transition happen on the same edge. No row is accepted in DRAIN/GAP even if valid is high.
- Reset mid-operation:
  - Shift registers, counters and FSM clear on the reset edge.
  - psum_en_row_o=0 from that edge onward; rows in flight are discarded.
  - After release, the next accepted row is row 0 of tile 0.
- Width rules: row_cnt is $clog2(TILE_ROWS+1) bits; tile_cnt is $clog2(TILE_NUM+1) bits; data is passed through unmodified.

Optional Feature:
- Macro: PSUM_SKEW_ZERO_FILL_EN.
- Defined: a lane's psum_row_o word is forced to 0 in every cycle its psum_en_row_o bit is 0.
- Undefined: a lane's data holds the last value shifted in, including bubble rows (no zero gating; fewer gates).
- Enable timing is identical in both builds.

Test Plan:
1. Reset: hold rst_n=1 for 2 cycles with valid=1 → all outputs 0, ready=1, busy=0, no accepts; first edge after release accepts.
2. Single tile, defaults, continuous valid, lane i data = row*16+i, first accept at T0:
   - en[13] rises at T0+1, en[0] at T0+14; each lane high for 70 consecutive cycles.
   - tile_done at T0+83; ready low T0+70..T0+88.
3. Bubble: drop valid for 1 cycle after row 10 → every lane shows a 1-cycle en=0 hole, lane i at offset 14-i; tile still ends after 70 accepted rows; tile_done delayed by 1 cycle.
4. 20 back-to-back tiles → 20 tile_done pulses; last_tile_o high only during tile 19; tile_cnt returns to 0 and last_tile_o drops at the 20th tile_done.
5. Reset asserted during row 30 of tile 2:
   - psum_en_row_o=0 from the next edge; tile_cnt=0.
   - After release, row 0 emerges on en[13] one cycle after its accept.
6. Optional macro defined vs undefined, with a bubble row whose data is 0xDEAD_BEEF:
   - Defined: psum_row_o lanes read 0 while en=0.
   - Undefined: lanes read 0xDEAD_BEEF in the hole cycle.
